// File: rtl/event_burst_generator_pkg.sv
// Shared definitions for the event burst source and the event counters that consume its strobes.
package event_burst_generator_pkg;

   localparam int CNT_W_DEF     = 4;
   localparam int GAP_W_DEF     = 4;
   localparam int MAX_BURST_DEF = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   // The counter side clamps with the same rule, so both ends agree on the longest burst.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/event_burst_generator_down_timer.sv
// Loadable down counter that times the idle gap between strobes.
module down_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // Load wins over decrement; the count parks at zero until the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/event_burst_generator.sv
// Emits a burst of single-cycle event strobes separated by a programmable gap, then flags completion.
module event_burst_generator
   import event_burst_generator_pkg::*;
#(
   parameter int          CNT_W     = CNT_W_DEF,
   parameter int          GAP_W     = GAP_W_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic [GAP_W-1:0] gap_len,
   input  logic             abort,
   output logic             strobe,
   output logic             busy,
   output logic [CNT_W-1:0] sent_count,
   output logic             done,
   output logic             done_pulse
);

   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic [GAP_W-1:0] gap_q;
   logic [CNT_W-1:0] len_clamped;
   logic [CNT_W-1:0] sent_next;
   logic             timer_load;
   logic             timer_dec;
   logic             timer_zero;

   assign len_clamped = CNT_W'(clamp_len(32'(burst_len), MAX_BURST));
   assign sent_next   = sent_count + CNT_W'(1);

   // The timer is armed as PULSE hands over to GAP, holding gap-1 so GAP lasts exactly gap cycles.
   assign timer_load = (state == PULSE) && !abort && (sent_next != len_q) && (gap_q != '0);
   assign timer_dec  = (state == GAP);

   down_timer #(
      .W(GAP_W)
   ) gap_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .load_value(gap_q - GAP_W'(1)),
      .dec       (timer_dec),
      .zero      (timer_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         strobe     <= 1'b0;
         busy       <= 1'b0;
         sent_count <= '0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         len_q      <= '0;
         gap_q      <= '0;
      end else begin
         done_pulse <= 1'b0;
         if (abort) begin
            // A strobe already on the wire in PULSE still counts toward the partial total.
            state  <= IDLE;
            strobe <= 1'b0;
            busy   <= 1'b0;
            if (state == PULSE) begin
               sent_count <= sent_next;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     len_q      <= len_clamped;
                     gap_q      <= gap_len;
                     sent_count <= '0;
                     if (len_clamped == '0) begin
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                     end else begin
                        done   <= 1'b0;
                        state  <= PULSE;
                        strobe <= 1'b1;
                        busy   <= 1'b1;
                     end
                  end
               end
               PULSE: begin
                  sent_count <= sent_next;
                  if (sent_next == len_q) begin
                     state      <= IDLE;
                     strobe     <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     done_pulse <= 1'b1;
                  end else if (gap_q == '0) begin
                     state  <= PULSE;
                     strobe <= 1'b1;
                  end else begin
                     state  <= GAP;
                     strobe <= 1'b0;
                  end
               end
               GAP: begin
                  if (timer_zero) begin
                     state  <= PULSE;
                     strobe <= 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  strobe <= 1'b0;
                  busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
